// File: rtl/clk_div_sched_if.sv
// Register-port bundle for clk_div_sched: write/read strobes, channel/register select and read-back.
interface clk_div_sched_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 24
) ();
    logic                    cfg_we;
    logic                    cfg_re;
    logic [$clog2(N_CH)-1:0] cfg_ch;
    logic [1:0]              cfg_reg;
    logic [CNT_W-1:0]        cfg_wdata;
    logic [CNT_W-1:0]        cfg_rdata;
    logic                    cfg_rvalid;

    modport master (
        output cfg_we, cfg_re, cfg_ch, cfg_reg, cfg_wdata,
        input  cfg_rdata, cfg_rvalid
    );

    modport slave (
        input  cfg_we, cfg_re, cfg_ch, cfg_reg, cfg_wdata,
        output cfg_rdata, cfg_rvalid
    );
endinterface

// File: rtl/clk_div_sched.sv
// Shared clock-divide scheduler: one global prescaler feeding N_CH divide channels (tick + 50% sclk).
// Optional macro CLK_DIV_SCHED_IRQ_EN adds a per-channel irq mask (CTRL bit2) and a registered irq output.
module clk_div_sched #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 24,
    parameter int PRE_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    clk_div_sched_if.slave  cfg,
    output logic [N_CH-1:0] tick,
    output logic [N_CH-1:0] sclk,
    output logic [N_CH-1:0] running
`ifdef CLK_DIV_SCHED_IRQ_EN
    ,
    output logic            irq
`endif
);
    localparam int CH_W = $clog2(N_CH);
    localparam logic [CH_W:0] N_CH_L = (CH_W + 1)'(N_CH);
    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_DIV      = 2'd1;
    localparam logic [1:0] REG_STATUS   = 2'd2;
    localparam logic [1:0] REG_PRESCALE = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} ch_state_t;

    logic [PRE_W-1:0] pcnt_reg;
    logic [PRE_W-1:0] prescale_reg;
    logic             pre_tick;
    logic             pre_wr;
    logic             ch_ok;
    logic [N_CH-1:0]  done_vec;
    logic [N_CH-1:0]  os_vec;
    logic [CNT_W-1:0] div_arr [N_CH];
    logic [CNT_W-1:0] rd_next;
    logic [CNT_W-1:0] rdata_reg;
    logic             rvalid_reg;
`ifdef CLK_DIV_SCHED_IRQ_EN
    logic [N_CH-1:0]  mask_vec;
    logic             irq_reg;
`endif

    assign pre_tick = (pcnt_reg == prescale_reg);
    assign pre_wr   = cfg.cfg_we && (cfg.cfg_reg == REG_PRESCALE);
    assign ch_ok    = ({1'b0, cfg.cfg_ch} < N_CH_L);

    // A PRESCALE write restarts the prescaler phase so the new ratio applies from a clean count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_reg     <= '0;
            prescale_reg <= '0;
        end else if (pre_wr) begin
            prescale_reg <= cfg.cfg_wdata[PRE_W-1:0];
            pcnt_reg     <= '0;
        end else if (pre_tick) begin
            pcnt_reg <= '0;
        end else begin
            pcnt_reg <= pcnt_reg + PRE_W'(1);
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        localparam logic [CH_W-1:0] IDX = CH_W'(gi);

        ch_state_t        state_reg;
        logic [CNT_W-1:0] cnt_reg;
        logic [CNT_W-1:0] div_reg;
        logic             tick_reg;
        logic             sclk_reg;
        logic             os_reg;
        logic             done_reg;
        logic             sel;
        logic             term;

        assign sel  = cfg.cfg_we && (cfg.cfg_ch == IDX);
        assign term = (state_reg == ST_RUN) && pre_tick && (cnt_reg >= div_reg);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_reg <= ST_IDLE;
                cnt_reg   <= '0;
                div_reg   <= '0;
                tick_reg  <= 1'b0;
                sclk_reg  <= 1'b0;
                os_reg    <= 1'b0;
                done_reg  <= 1'b0;
            end else begin
                tick_reg <= term;
                if (term) begin
                    sclk_reg <= ~sclk_reg;
                end

                case (state_reg)
                    ST_RUN: begin
                        if (pre_tick) begin
                            if (term) begin
                                cnt_reg <= '0;
                                if (os_reg) begin
                                    state_reg <= ST_DONE;
                                end
                            end else begin
                                cnt_reg <= cnt_reg + CNT_W'(1);
                            end
                        end
                    end
                    default: cnt_reg <= '0;
                endcase

                // A done-set on this edge beats a coincident write-one-to-clear.
                if (term && os_reg) begin
                    done_reg <= 1'b1;
                end else if (sel && (cfg.cfg_reg == REG_STATUS) && cfg.cfg_wdata[1]) begin
                    done_reg <= 1'b0;
                end

                if (sel && (cfg.cfg_reg == REG_DIV)) begin
                    div_reg <= cfg.cfg_wdata;
                end

                // CTRL writes override whatever state the terminal-count logic above selected.
                if (sel && (cfg.cfg_reg == REG_CTRL)) begin
                    os_reg <= cfg.cfg_wdata[1];
                    if (!cfg.cfg_wdata[0]) begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= '0;
                    end else if (state_reg != ST_RUN) begin
                        state_reg <= ST_RUN;
                        cnt_reg   <= '0;
                    end else begin
                        state_reg <= ST_RUN;
                    end
                end
            end
        end

`ifdef CLK_DIV_SCHED_IRQ_EN
        logic mask_reg;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mask_reg <= 1'b0;
            end else if (sel && (cfg.cfg_reg == REG_CTRL)) begin
                mask_reg <= cfg.cfg_wdata[2];
            end
        end
        assign mask_vec[gi] = mask_reg;
`endif

        assign tick[gi]     = tick_reg;
        assign sclk[gi]     = sclk_reg;
        assign running[gi]  = (state_reg == ST_RUN);
        assign done_vec[gi] = done_reg;
        assign os_vec[gi]   = os_reg;
        assign div_arr[gi]  = div_reg;
    end

    always_comb begin
        rd_next = '0;
        if (cfg.cfg_reg == REG_PRESCALE) begin
            rd_next[PRE_W-1:0] = prescale_reg;
        end else if (ch_ok) begin
            case (cfg.cfg_reg)
                REG_CTRL: begin
                    rd_next[0] = running[cfg.cfg_ch];
                    rd_next[1] = os_vec[cfg.cfg_ch];
`ifdef CLK_DIV_SCHED_IRQ_EN
                    rd_next[2] = mask_vec[cfg.cfg_ch];
`endif
                end
                REG_DIV:    rd_next = div_arr[cfg.cfg_ch];
                REG_STATUS: rd_next[1:0] = {done_vec[cfg.cfg_ch], running[cfg.cfg_ch]};
                default:    rd_next = '0;
            endcase
        end
    end

    // Read data is captured from pre-edge state, so a same-cycle write is not yet visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_reg  <= '0;
            rvalid_reg <= 1'b0;
        end else begin
            rvalid_reg <= cfg.cfg_re;
            rdata_reg  <= cfg.cfg_re ? rd_next : '0;
        end
    end

    assign cfg.cfg_rdata  = rdata_reg;
    assign cfg.cfg_rvalid = rvalid_reg;

`ifdef CLK_DIV_SCHED_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= |(done_vec & mask_vec);
        end
    end
    assign irq = irq_reg;
`endif
endmodule

// File: tb/tb_clk_div_sched.sv
// Self-checking bench for clk_div_sched: directed scenarios plus randomized register traffic vs. a behavioural model.
module tb_clk_div_sched;
    localparam int N_CH  = 4;
    localparam int CNT_W = 24;
    localparam int PRE_W = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N_CH-1:0] tick;
    logic [N_CH-1:0] sclk;
    logic [N_CH-1:0] running;
`ifdef CLK_DIV_SCHED_IRQ_EN
    logic            irq;
`endif

    always #5 clk = ~clk;

    clk_div_sched_if #(.N_CH(N_CH), .CNT_W(CNT_W)) cfg_if ();

    clk_div_sched #(.N_CH(N_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cfg     (cfg_if),
        .tick    (tick),
        .sclk    (sclk),
        .running (running)
`ifdef CLK_DIV_SCHED_IRQ_EN
        ,
        .irq     (irq)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: register file and channel progress in plain integers.
    int unsigned m_pcnt, m_pre;
    int unsigned m_cnt [N_CH];
    int unsigned m_div [N_CH];
    bit m_run [N_CH], m_os [N_CH], m_mask [N_CH], m_done [N_CH], m_tick [N_CH], m_sclk [N_CH];
    bit m_rvalid, m_irq;
    int unsigned m_rdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pcnt = 0; m_pre = 0; m_rvalid = 0; m_rdata = 0; m_irq = 0;
        for (int c = 0; c < N_CH; c++) begin
            m_cnt[c] = 0; m_div[c] = 0; m_run[c] = 0; m_os[c] = 0;
            m_mask[c] = 0; m_done[c] = 0; m_tick[c] = 0; m_sclk[c] = 0;
        end
    endtask

    function automatic bit m_term(input int c);
        return m_run[c] && (m_pcnt == m_pre) && (m_cnt[c] >= m_div[c]);
    endfunction

    task automatic model_edge();
        bit pt;
        bit we, re, term, was_run, old_os;
        int ch, rg;
        int unsigned wd;
        pt = (m_pcnt == m_pre);
        we = cfg_if.cfg_we; re = cfg_if.cfg_re;
        ch = int'(cfg_if.cfg_ch); rg = int'(cfg_if.cfg_reg); wd = cfg_if.cfg_wdata;
        m_rvalid = re;
        m_rdata  = 0;
        if (re) begin
            case (rg)
                0: m_rdata = m_run[ch] | (m_os[ch] << 1) | (m_mask[ch] << 2);
                1: m_rdata = m_div[ch];
                2: m_rdata = m_run[ch] | (m_done[ch] << 1);
                default: m_rdata = m_pre;
            endcase
        end
        m_irq = 0;
        for (int c = 0; c < N_CH; c++) if (m_done[c] && m_mask[c]) m_irq = 1;
        for (int c = 0; c < N_CH; c++) begin
            term = m_term(c); was_run = m_run[c]; old_os = m_os[c];
            m_tick[c] = term;
            if (term) m_sclk[c] = !m_sclk[c];
            if (was_run && pt) begin
                if (term) begin
                    m_cnt[c] = 0;
                    if (old_os) begin m_run[c] = 0; m_done[c] = 1; end
                end else begin
                    m_cnt[c] = m_cnt[c] + 1;
                end
            end
            if (we && ch == c) begin
                case (rg)
                    0: begin
                        if (wd[0]) begin
                            m_run[c] = 1;
                            if (!was_run) m_cnt[c] = 0;
                        end else begin
                            m_run[c] = 0; m_cnt[c] = 0;
                        end
                        m_os[c] = wd[1];
`ifdef CLK_DIV_SCHED_IRQ_EN
                        m_mask[c] = wd[2];
`endif
                    end
                    1: m_div[c] = wd;
                    2: if (wd[1] && !(term && old_os)) m_done[c] = 0;
                    default: ;
                endcase
            end
        end
        if (we && rg == 3) begin
            m_pre = wd & 32'hFF; m_pcnt = 0;
        end else begin
            m_pcnt = pt ? 0 : m_pcnt + 1;
        end
    endtask

    task automatic check_outputs();
        for (int c = 0; c < N_CH; c++) begin
            chk($sformatf("tick%0d", c), 32'(tick[c]), 32'(m_tick[c]));
            chk($sformatf("sclk%0d", c), 32'(sclk[c]), 32'(m_sclk[c]));
            chk($sformatf("running%0d", c), 32'(running[c]), 32'(m_run[c]));
        end
        chk("rvalid", 32'(cfg_if.cfg_rvalid), 32'(m_rvalid));
        if (m_rvalid) chk("rdata", 32'(cfg_if.cfg_rdata), m_rdata);
`ifdef CLK_DIV_SCHED_IRQ_EN
        chk("irq", 32'(irq), 32'(m_irq));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic wr(input int ch, input int rg, input int unsigned d);
        cfg_if.cfg_we = 1'b1; cfg_if.cfg_ch = 2'(ch); cfg_if.cfg_reg = 2'(rg); cfg_if.cfg_wdata = CNT_W'(d);
        step();
        cfg_if.cfg_we = 1'b0;
    endtask

    task automatic rd(input int ch, input int rg, output int unsigned v);
        cfg_if.cfg_re = 1'b1; cfg_if.cfg_ch = 2'(ch); cfg_if.cfg_reg = 2'(rg);
        step();
        cfg_if.cfg_re = 1'b0;
        v = cfg_if.cfg_rdata;
    endtask

    task automatic wait_tick(input int c, input int budget, output int n);
        n = 0;
        do begin step(); n++; end while (!tick[c] && n < budget);
        chk($sformatf("tick%0d_seen", c), 32'(tick[c]), 32'd1);
    endtask

    task automatic wait_term(input int c, input int budget);
        int n = 0;
        while (!m_term(c) && n < budget) begin step(); n++; end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, extra;
        int unsigned v;
        cfg_if.cfg_we = 0; cfg_if.cfg_re = 0; cfg_if.cfg_ch = 0; cfg_if.cfg_reg = 0; cfg_if.cfg_wdata = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_tick", 32'(tick), 0);
        chk("reset_sclk", 32'(sclk), 0);
        chk("reset_running", 32'(running), 0);
        chk("reset_rvalid", 32'(cfg_if.cfg_rvalid), 0);
        rst_n = 1'b1;
        step();

        // Continuous ch0, PRESCALE=0, DIV=3
        wr(0, 1, 3); wr(0, 0, 1);
        wait_tick(0, 20, n); chk("t1_first_latency", n, 4);
        chk("t1_running", 32'(running[0]), 1);
        wait_tick(0, 20, n); chk("t1_period", n, 4);

        // ch1 with PRESCALE=2, then PRESCALE=0 mid-run
        wr(0, 3, 2); wr(1, 1, 1); wr(1, 0, 1);
        wait_tick(1, 40, n); wait_tick(1, 40, n); chk("t2_period_p2", n, 6);
        wr(0, 3, 0);
        wait_tick(1, 40, n); wait_tick(1, 40, n); chk("t2_period_p0", n, 2);

        // One-shot ch2
        wr(2, 1, 5); wr(2, 0, 3);
        wait_tick(2, 20, n); chk("t3_oneshot_latency", n, 6);
        extra = 0;
        repeat (20) begin step(); if (tick[2]) extra++; end
        chk("t3_single_tick", extra, 0);
        rd(2, 2, v); chk("t3_status_done", v, 2);
        chk("t3_running", 32'(running[2]), 0);
        wr(2, 2, 2); rd(2, 2, v); chk("t3_status_cleared", v, 0);
        wr(2, 0, 3); wait_tick(2, 20, n); chk("t3_retrigger", n, 6);

        // DIV shrink below current count
        wr(0, 0, 0); wr(0, 1, 100); wr(0, 0, 1);
        repeat (50) step();
        wr(0, 1, 10);
        wait_tick(0, 5, n); chk("t4_immediate_terminal", n, 1);
        wait_tick(0, 20, n); chk("t4_new_period", n, 11);

        // CTRL writes coincident with a terminal count
        wait_term(1, 10); wr(1, 0, 1);
        chk("t5_tick_on_reenable", 32'(tick[1]), 1);
        wait_term(1, 10); wr(1, 0, 0);
        chk("t5_tick_on_disable", 32'(tick[1]), 1);
        chk("t5_disabled", 32'(running[1]), 0);

        // W1C coincident with done-set
        wr(2, 2, 2); wr(2, 0, 3);
        wait_term(2, 20); wr(2, 2, 2);
        rd(2, 2, v); chk("t5_done_set_wins", v, 2);

        // Asynchronous reset mid-count
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_tick", 32'(tick), 0);
        chk("rst_async_sclk", 32'(sclk), 0);
        chk("rst_async_running", 32'(running), 0);
        chk("rst_async_rvalid", 32'(cfg_if.cfg_rvalid), 0);
        chk("rst_async_rdata", 32'(cfg_if.cfg_rdata), 0);
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        extra = 0;
        repeat (30) begin step(); if (tick != 0) extra++; end
        chk("rst_no_ticks", extra, 0);
        wr(0, 1, 3); wr(0, 0, 1);
        wait_tick(0, 20, n); chk("rst_reenable_latency", n, 4);

`ifdef CLK_DIV_SCHED_IRQ_EN
        wr(3, 1, 2); wr(3, 0, 7);
        wait_tick(3, 20, n);
        chk("irq_lags_done", 32'(irq), 0);
        step(); chk("irq_asserted", 32'(irq), 1);
        wr(3, 2, 2); chk("irq_hold_on_clear", 32'(irq), 1);
        step(); chk("irq_deasserted", 32'(irq), 0);
        wr(3, 0, 3);
        wait_tick(3, 20, n);
        extra = 0;
        repeat (5) begin step(); if (irq) extra++; end
        chk("irq_masked", extra, 0);
`endif

        // Randomized register traffic against the model
        for (int i = 0; i < 2500; i++) begin
            int r, rg;
            r  = int'($urandom_range(0, 9));
            rg = int'($urandom_range(0, 3));
            cfg_if.cfg_we  = (r < 3);
            cfg_if.cfg_re  = (r >= 2 && r < 5);
            cfg_if.cfg_ch  = 2'($urandom_range(0, N_CH - 1));
            cfg_if.cfg_reg = 2'(rg);
            case (rg)
                0:       cfg_if.cfg_wdata = CNT_W'($urandom_range(0, 7));
                1:       cfg_if.cfg_wdata = CNT_W'($urandom_range(0, 6));
                2:       cfg_if.cfg_wdata = CNT_W'($urandom_range(0, 3));
                default: cfg_if.cfg_wdata = CNT_W'($urandom_range(0, 2));
            endcase
            step();
        end
        cfg_if.cfg_we = 0; cfg_if.cfg_re = 0;
        repeat (20) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/clk_div_sched.md
Name: clk_div_sched

Overview:
- Shared clock-divide scheduler. One global prescaler feeds N_CH independent divide channels.
- Each channel is configured over a simple register port and runs continuous or one-shot.
- Each channel emits a one-cycle tick enable and a 50%-duty toggling slow clock.
- Replaces per-consumer free-running dividers (LED blink, display scan, sampling strobes) with one configurable, software-controlled resource.

Parameters:
- N_CH, 4, number of divide channels (2..8)
- CNT_W, 24, width of channel counter and DIV register
- PRE_W, 8, width of global prescaler counter and PRESCALE register

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  register write strobe, sampled on rising clk
- cfg_re  in  1  register read strobe
- cfg_ch  in  $clog2(N_CH)  channel select
- cfg_reg  in  2  register select: 0 CTRL, 1 DIV, 2 STATUS, 3 PRESCALE (global; cfg_ch ignored)
- cfg_wdata  in  CNT_W  write data
- cfg_rdata  out  CNT_W  read data, registered
- cfg_rvalid  out  1  read data valid
- tick  out  N_CH  per-channel one-cycle terminal pulse
- sclk  out  N_CH  per-channel toggling slow clock
- running  out  N_CH  channel in RUN state

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Values on reset:
  - all channels IDLE
  - counters, DIV, PRESCALE, tick, sclk, running, cfg_rdata, cfg_rvalid all 0
  - done flags clear
- Prescaler:
  - pcnt counts 0..PRESCALE.
  - pre_tick = (pcnt == PRESCALE) is combinational; pcnt returns to 0 on the same edge.
  - PRESCALE=0 gives pre_tick every cycle.
  - A PRESCALE write clears pcnt to 0.
- Channel states:
  - IDLE: counter held at 0.
  - RUN: on each edge with pre_tick:
    - if cnt >= DIV: cnt<=0, tick<=1 for one cycle, sclk toggles.
    - else cnt<=cnt+1.
  - DONE: entered from RUN at terminal count when one_shot=1. It sets the sticky done flag and clears CTRL.enable. sclk holds its last value.
- CTRL register: bit0 enable, bit1 one_shot.
  - Write with enable=1 from IDLE or DONE: RUN, cnt<=0.
  - Write with enable=1 while already RUN: no restart; only one_shot is updated.
  - Write with enable=0: IDLE, cnt<=0, sclk holds.
- Timing: with PRESCALE=P and DIV=D, tick period is (P+1)(D+1) cycles. The first tick is asserted (P+1)(D+1) cycles after the enable write edge.
- DIV write while running:
  - takes effect immediately;
  - the >= compare guarantees a terminal count at the next pre_tick if cnt already exceeds the new DIV.
- STATUS register (read): bit0 running, bit1 done.
  - Writing 1 to bit1 clears done; writes to other bits are ignored.
- Reads:
  - cfg_re at edge N gives cfg_rdata/cfg_rvalid valid in cycle N+1 for one cycle.
  - Unused bits read 0.
  - cfg_we and cfg_re in the same cycle: the read returns the pre-write value.
- Simultaneous events:
  - CTRL write coincident with a terminal count: the tick is still emitted and sclk still toggles; the written state wins.
  - done-set coincident with a W1C clear: set wins.
- Invalid channel: cfg_ch >= N_CH writes are dropped; reads return 0.
- Reset mid-operation: all state is cleared immediately and asynchronously. No tick is emitted on or after reset release until a channel is re-enabled.

Optional Feature:
- Macro: CLK_DIV_SCHED_IRQ_EN
- When defined:
  - CTRL bit2 becomes irq_mask per channel.
  - Output port irq (1 bit, registered) = OR over channels of (done & irq_mask).
  - irq deasserts the cycle after the last contributing done is cleared or masked.
  - irq resets to 0.
- When undefined:
  - irq port is absent.
  - CTRL bit2 is ignored and reads 0.

Test Plan:
- Reset, then PRESCALE=0, ch0 DIV=3, CTRL=0x1 -> tick[0] pulses every 4 cycles, first pulse 4 cycles after the write; sclk[0] toggles on each tick; running[0]=1.
- PRESCALE=2, ch1 DIV=1, continuous -> tick[1] period 6 cycles. Then write PRESCALE=0 mid-run -> period becomes 2 cycles from the next pre_tick.
- ch2 DIV=5, CTRL=0x3 (one-shot) -> exactly one tick after 6 cycles; STATUS reads 0x2; running[2]=0. Write STATUS=0x2 -> STATUS reads 0x0. Re-enable -> one further tick.
- ch0 running DIV=100 with cnt~50, write DIV=10 -> terminal on the next pre_tick. Then period 11 cycles.
- Enable write coincident with a terminal edge, W1C coincident with done-set, and rst_n pulsed low mid-count -> all outputs 0 asynchronously and no ticks until re-enabled; done remains set after the coincident W1C.
- With CLK_DIV_SCHED_IRQ_EN: ch3 one-shot DIV=2, CTRL=0x7 -> irq=1 the cycle after done. STATUS W1C -> irq=0 next cycle. Mask=0 -> irq never asserts.
